// File: rtl/pll_cen_gen.sv
//------------------------------------------------------------------------------
// pll_cen_gen : lock-qualified, multi-channel fractional clock-enable generator
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pll_cen_gen #(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 24,
    parameter int                      CH_AW       = 1,
    parameter int                      LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = {NUM_CH{24'h400000}}
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              resync,
    input  logic              cfg_we,
    input  logic [CH_AW-1:0]  cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam int               c_CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_MAX = c_CNT_W'(LOCK_CYCLES);

    logic               r_sync1;
    logic               r_lk_s;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic               r_locked;

    // Any low synchronised sample restarts the full settle count.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_lk_s     <= 1'b0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_lk_s  <= r_sync1;
            if (!r_lk_s) begin
                r_lock_cnt <= '0;
            end else if (r_lock_cnt != c_LOCK_MAX) begin
                r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
            end
            r_locked <= r_lk_s && (r_lock_cnt == c_LOCK_MAX);
        end
    end

    assign locked = r_locked;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] r_inc;
        logic [ACC_W-1:0] r_pending;
        logic             r_pend;
        logic             r_ce;
        logic [ACC_W:0]   w_sum;
        logic             w_wr;
        logic             w_xfer;

        assign w_sum  = {1'b0, r_acc} + {1'b0, r_inc};
        assign w_wr   = cfg_we && (cfg_ch == CH_AW'(i));
        // New rate only takes over at a pulse boundary or when nothing is running.
        assign w_xfer = r_pend && (w_sum[ACC_W] || (r_inc == '0) || !r_locked || resync);

        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                r_acc     <= '0;
                r_ce      <= 1'b0;
                r_inc     <= INIT_INC[i*ACC_W +: ACC_W];
                r_pending <= '0;
                r_pend    <= 1'b0;
            end else begin
                if (!r_locked || resync) begin
                    r_acc <= '0;
                    r_ce  <= 1'b0;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_ce  <= w_sum[ACC_W];
                end

                if (w_xfer) begin
                    r_inc <= r_pending;
                end

                if (w_wr) begin
                    r_pending <= cfg_inc;
                    r_pend    <= 1'b1;
                end else if (w_xfer) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign ce[i] = r_ce;
    end

endmodule

`default_nettype wire
